gb_frame_sequencer_v2: RTL and testbench
========================================

Name: gb_frame_sequencer_v2

Overview:
- Parametrised successor to the APU frame sequencer.
- Drives the Length, Envelope and Sweep clocks from an explicit 8-step state machine instead of fixed divider compares.
- Adds APU power gating (NR52 bit 7), DIV-register reset glitch handling, a selectable external DIV-bit tick source, a step-index output, and a "next step clocks length" flag for channel length quirks.
- Sits between the system clock and all four channel modules.

Parameters:
- DIV_W, 13, internal divider width; one sequencer step per 2^DIV_W enabled clocks (13 -> 512 Hz at 2^22 Hz).
- EXT_DIV, 0, tick source: 0 = internal divider; 1 = falling edge of ext_div_bit.
- ENV_STEP, 7, step index (0-7) on which envelope_clk fires.

Ports:
- clk  input  1  system clock, 2^22 Hz T-cycle.
- reset  input  1  asynchronous, active-high reset.
- apu_en  input  1  APU power (NR52 bit 7); low holds the sequencer idle.
- div_reset  input  1  one-cycle pulse on a CPU write to DIV.
- ext_div_bit  input  1  DIV bit used as tick source when EXT_DIV=1; ignored otherwise.
- length_clk  output  1  one-cycle pulse, 256 Hz.
- sweep_clk  output  1  one-cycle pulse, 128 Hz.
- envelope_clk  output  1  one-cycle pulse, 64 Hz.
- step  output  3  index of the next step to execute.
- next_no_len  output  1  high when the next step to execute does not clock length (step odd).

Behaviour:
- Reset is asynchronous and active-high: div=0, step=0, ext_prev=0, all pulses 0, next_no_len=0.
- Internal tick (EXT_DIV=0), with apu_en=1:
  - div increments every clock.
  - tick=1 on the edge where div == all ones; div wraps to 0.
- div_reset=1 (EXT_DIV=0):
  - div is cleared to 0; no increment that cycle.
  - If div[DIV_W-1]==1 at that edge, a tick occurs (falling-edge glitch of the DIV bit).
  - If div == all ones and div_reset=1, exactly one tick occurs.
- External tick (EXT_DIV=1):
  - ext_prev registers ext_div_bit every clock.
  - tick=1 when ext_prev==1 && ext_div_bit==0 && apu_en==1.
  - div is unused, held at 0; div_reset has no effect.
- Tick with current step s (all updates on the same edge):
  - length_clk <= (s[0]==0).
  - sweep_clk <= (s==2 || s==6).
  - envelope_clk <= (s==ENV_STEP).
  - step <= s+1, wrapping 7 -> 0.
- Without a tick, all pulses <= 0. Pulses are registered and high for exactly one cycle, in the cycle after the tick edge.
- next_no_len = step[0], combinational from the registered step.
- apu_en=0:
  - Synchronously forces div=0, step=0, all pulses 0. Takes priority over tick and div_reset.
  - ext_prev still tracks ext_div_bit, so no false edge on re-enable.
- apu_en 0->1 (internal mode): the first tick occurs 2^DIV_W edges later and executes step 0 (length_clk=1).
- Reset mid-operation: immediate return to reset values; any in-flight pulse is cleared.

Optional Feature:
- Macro: GB_FS_FAST_FWD_EN.
- Defined:
  - Adds input port fast_fwd (1 bit).
  - When fast_fwd=1 and apu_en=1, tick=1 on every clock regardless of divider or ext source; div still counts normally.
  - Used by simulation and debug to walk all 8 steps in 8 cycles.
- Undefined: port absent; tick only from the selected source.

Test Plan:
- Reset, apu_en=1, DIV_W=13 -> first length_clk in cycle 8192 after enable; sweep_clk first after 3 ticks (step 2); envelope_clk first after 8 ticks (step 7); step sequence 1,2,...,7,0.
- Run 8 ticks, count pulses -> length=4, sweep=2, envelope=1; pulses never overlap except length+sweep at steps 2/6; next_no_len toggles each tick.
- div_reset pulse when div=0x1000 -> tick that edge, step advances, div=0. div_reset when div=0x0100 -> no tick, div=0.
- apu_en dropped at step 5 then raised -> step=0 immediately; next tick 8192 cycles later produces length_clk=1 with step 0->1.
- EXT_DIV=1: drive ext_div_bit 1->0 ->
  - one tick, pulses one cycle later;
  - 0->1 edge -> no tick;
  - falling edge while apu_en=0 -> ignored.
- GB_FS_FAST_FWD_EN defined, fast_fwd=1 for 8 cycles -> full step cycle in 8 cycles, envelope_clk once; async reset asserted mid-pulse -> all outputs 0 that cycle.

Source files
------------

// File: rtl/gb_frame_sequencer_v2.sv
// APU frame sequencer: 8-step machine producing length/sweep/envelope clocks.
// Optional GB_FS_FAST_FWD_EN adds a fast_fwd input that ticks every enabled clock.
module gb_frame_sequencer_v2 #(
  parameter int DIV_W    = 13,
  parameter int EXT_DIV  = 0,
  parameter int ENV_STEP = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_en,
  input  logic       div_reset,
  input  logic       ext_div_bit,
`ifdef GB_FS_FAST_FWD_EN
  input  logic       fast_fwd,
`endif
  output logic       length_clk,
  output logic       sweep_clk,
  output logic       envelope_clk,
  output logic [2:0] step,
  output logic       next_no_len
);

  typedef enum logic [2:0] {
    ST0, ST1, ST2, ST3, ST4, ST5, ST6, ST7
  } step_e;

  step_e            step_q, step_d;
  logic [DIV_W-1:0] div_q, div_nxt, div_d;
  logic             ext_prev_q;
  logic             len_q, len_d;
  logic             swp_q, swp_d;
  logic             env_q, env_d;
  logic             tick_src, tick;

  generate
    if (EXT_DIV != 0) begin : g_ext
      // Divider is parked; the falling edge of the external DIV bit is the tick.
      assign div_nxt  = '0;
      assign tick_src = ext_prev_q & ~ext_div_bit;
    end else begin : g_int
      logic unused_ext;
      assign unused_ext = ext_prev_q;
      // A DIV write while the top bit is set looks like a falling edge to the APU.
      always_comb begin
        if (div_reset) begin
          div_nxt  = '0;
          tick_src = div_q[DIV_W-1];
        end else begin
          div_nxt  = div_q + DIV_W'(1);
          tick_src = &div_q;
        end
      end
    end
  endgenerate

`ifdef GB_FS_FAST_FWD_EN
  assign tick = apu_en & (tick_src | fast_fwd);
`else
  assign tick = apu_en & tick_src;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q     <= ST0;
      div_q      <= '0;
      ext_prev_q <= 1'b0;
      len_q      <= 1'b0;
      swp_q      <= 1'b0;
      env_q      <= 1'b0;
    end else begin
      step_q     <= step_d;
      div_q      <= div_d;
      ext_prev_q <= ext_div_bit;
      len_q      <= len_d;
      swp_q      <= swp_d;
      env_q      <= env_d;
    end
  end

  always_comb begin
    step_d = step_q;
    div_d  = div_nxt;
    len_d  = 1'b0;
    swp_d  = 1'b0;
    env_d  = 1'b0;
    if (!apu_en) begin
      step_d = ST0;
      div_d  = '0;
    end else if (tick) begin
      len_d = ~step_q[0];
      swp_d = (step_q == ST2) || (step_q == ST6);
      env_d = (step_q == step_e'(3'(ENV_STEP)));
      case (step_q)
        ST0:     step_d = ST1;
        ST1:     step_d = ST2;
        ST2:     step_d = ST3;
        ST3:     step_d = ST4;
        ST4:     step_d = ST5;
        ST5:     step_d = ST6;
        ST6:     step_d = ST7;
        default: step_d = ST0;
      endcase
    end
  end

  assign length_clk   = len_q;
  assign sweep_clk    = swp_q;
  assign envelope_clk = env_q;
  assign step         = step_q;
  assign next_no_len  = step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer_v2.sv
// Directed bench: three sequencer instances (DIV_W=13, DIV_W=4, external DIV source).
module tb_gb_frame_sequencer_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_en, a_dr, a_ext, b_en, b_dr, b_ext, c_en, c_dr, c_ext;
  logic a_len, a_swp, a_env, a_nnl;
  logic b_len, b_swp, b_env, b_nnl;
  logic c_len, c_swp, c_env, c_nnl;
  logic [2:0] a_step, b_step, c_step;
`ifdef GB_FS_FAST_FWD_EN
  logic a_ff, b_ff, c_ff;
`endif

  int n_chk = 0;
  int n_pass = 0;

  gb_frame_sequencer_v2 #(.DIV_W(13), .EXT_DIV(0), .ENV_STEP(7)) u_a (
    .clk(clk), .reset(rst), .apu_en(a_en), .div_reset(a_dr), .ext_div_bit(a_ext),
`ifdef GB_FS_FAST_FWD_EN
    .fast_fwd(a_ff),
`endif
    .length_clk(a_len), .sweep_clk(a_swp), .envelope_clk(a_env),
    .step(a_step), .next_no_len(a_nnl));

  gb_frame_sequencer_v2 #(.DIV_W(4), .EXT_DIV(0), .ENV_STEP(7)) u_b (
    .clk(clk), .reset(rst), .apu_en(b_en), .div_reset(b_dr), .ext_div_bit(b_ext),
`ifdef GB_FS_FAST_FWD_EN
    .fast_fwd(b_ff),
`endif
    .length_clk(b_len), .sweep_clk(b_swp), .envelope_clk(b_env),
    .step(b_step), .next_no_len(b_nnl));

  gb_frame_sequencer_v2 #(.DIV_W(4), .EXT_DIV(1), .ENV_STEP(7)) u_c (
    .clk(clk), .reset(rst), .apu_en(c_en), .div_reset(c_dr), .ext_div_bit(c_ext),
`ifdef GB_FS_FAST_FWD_EN
    .fast_fwd(c_ff),
`endif
    .length_clk(c_len), .sweep_clk(c_swp), .envelope_clk(c_env),
    .step(c_step), .next_no_len(c_nnl));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_len, n_swp, n_env, exp_v;
    rst = 1'b1;
    {a_en, a_dr, a_ext, b_en, b_dr, b_ext, c_en, c_dr, c_ext} = '0;
`ifdef GB_FS_FAST_FWD_EN
    {a_ff, b_ff, c_ff} = '0;
`endif
    clks(2);
    chk("rst_a_out", 32'({a_len, a_swp, a_env, a_step, a_nnl}), 0);
    chk("rst_b_out", 32'({b_len, b_swp, b_env, b_step, b_nnl}), 0);
    chk("rst_c_out", 32'({c_len, c_swp, c_env, c_step, c_nnl}), 0);
    rst = 1'b0;

    // Instance A: first tick 8192 edges after enable, executes step 0.
    a_en = 1'b1;
    clks(8191);
    chk("a_pre_tick", 32'({a_len, a_step}), 0);
    clks(1);
    chk("a_first_len", 32'(a_len), 1);
    chk("a_first_step", 32'(a_step), 1);
    chk("a_first_nnl", 32'(a_nnl), 1);
    chk("a_first_swp_env", 32'({a_swp, a_env}), 0);
    clks(1);
    chk("a_len_one_cycle", 32'(a_len), 0);
    // div now 1; walk it to 0x1000 and write DIV: glitch tick executes step 1.
    clks(32'h0FFF);
    a_dr = 1'b1;
    clks(1);
    a_dr = 1'b0;
    chk("a_dr_1000_step", 32'(a_step), 2);
    chk("a_dr_1000_len", 32'(a_len), 0);
    clks(32'h0100);
    a_dr = 1'b1;
    clks(1);
    a_dr = 1'b0;
    chk("a_dr_0100_step", 32'(a_step), 2);
    chk("a_dr_0100_pulses", 32'({a_len, a_swp, a_env}), 0);
    // Divider was cleared, so the next tick is a full 8192 edges away.
    clks(8191);
    chk("a_after_dr_pre", 32'({a_len, a_step}), 2);
    clks(1);
    chk("a_after_dr_tick", 32'({a_len, a_swp, a_env, a_step}), 32'b110_011);
    a_en = 1'b0;

    // Instance B: full 8-step cycle, 16 edges per tick.
    b_en = 1'b1;
    n_len = 0; n_swp = 0; n_env = 0;
    for (int t = 0; t < 8; t++) begin
      clks(15);
      chk("b_idle", 32'({b_len, b_swp, b_env}), 0);
      clks(1);
      exp_v = ((t % 2 == 0) ? 4 : 0) | ((t == 2 || t == 6) ? 2 : 0) | ((t == 7) ? 1 : 0);
      chk($sformatf("b_pulse_s%0d", t), 32'({b_len, b_swp, b_env}), exp_v);
      chk($sformatf("b_step_s%0d", t), 32'(b_step), (t + 1) % 8);
      chk($sformatf("b_nnl_s%0d", t), 32'(b_nnl), (t + 1) % 2);
      n_len += 32'(b_len); n_swp += 32'(b_swp); n_env += 32'(b_env);
    end
    chk("b_cnt_len", n_len, 4);
    chk("b_cnt_swp", n_swp, 2);
    chk("b_cnt_env", n_env, 1);

    // Power gate at step 5, then re-enable.
    clks(80);
    chk("b_at_step5", 32'(b_step), 5);
    clks(3);
    b_en = 1'b0;
    clks(1);
    chk("b_off_out", 32'({b_len, b_swp, b_env, b_step, b_nnl}), 0);
    clks(4);
    b_en = 1'b1;
    clks(15);
    chk("b_reen_pre", 32'({b_len, b_step}), 0);
    clks(1);
    chk("b_reen_tick", 32'({b_len, b_step}), 32'b1_001);

    // DIV write with divider all ones: exactly one tick.
    clks(15);
    b_dr = 1'b1;
    clks(1);
    b_dr = 1'b0;
    chk("b_dr_ones_step", 32'(b_step), 2);
    clks(1);
    chk("b_dr_ones_single", 32'(b_step), 2);
    clks(14);
    chk("b_dr_ones_pre", 32'({b_len, b_step}), 2);
    clks(1);
    chk("b_dr_ones_next", 32'({b_len, b_swp, b_env, b_step}), 32'b110_011);

    // Instance C: external DIV bit falling edge.
    c_en = 1'b1;
    clks(1);
    c_ext = 1'b1;
    clks(1);
    chk("c_rise_none", 32'({c_len, c_swp, c_env, c_step}), 0);
    c_ext = 1'b0;
    clks(1);
    chk("c_fall_tick", 32'({c_len, c_step}), 32'b1_001);
    clks(1);
    chk("c_len_one_cycle", 32'(c_len), 0);
    c_ext = 1'b1;
    clks(1);
    chk("c_rise_no_tick", 32'({c_len, c_step}), 1);
    c_ext = 1'b0;
    c_en = 1'b0;
    clks(1);
    chk("c_fall_disabled", 32'({c_len, c_swp, c_env, c_step}), 0);
    c_en = 1'b1;
    clks(1);
    chk("c_reen_no_edge", 32'({c_len, c_step}), 0);
    c_ext = 1'b1;
    clks(1);
    c_ext = 1'b0;
    c_dr = 1'b1;
    clks(1);
    c_dr = 1'b0;
    chk("c_dr_ignored", 32'({c_len, c_step}), 32'b1_001);
    // Asynchronous reset lands while length_clk is high.
    rst = 1'b1;
    #1;
    chk("c_async_rst", 32'({c_len, c_swp, c_env, c_step, c_nnl}), 0);
    chk("b_async_rst", 32'({b_len, b_swp, b_env, b_step, b_nnl}), 0);
    #2;
    rst = 1'b0;

`ifdef GB_FS_FAST_FWD_EN
    clks(1);
    b_ff = 1'b1;
    n_len = 0; n_swp = 0; n_env = 0;
    for (int i = 0; i < 8; i++) begin
      clks(1);
      chk($sformatf("ff_step%0d", i), 32'(b_step), (i + 1) % 8);
      n_len += 32'(b_len); n_swp += 32'(b_swp); n_env += 32'(b_env);
    end
    b_ff = 1'b0;
    chk("ff_cnt_len", n_len, 4);
    chk("ff_cnt_swp", n_swp, 2);
    chk("ff_cnt_env", n_env, 1);
    clks(1);
    chk("ff_off_idle", 32'({b_len, b_swp, b_env, b_step}), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
